// File: rtl/hls_chn_o_pkg.sv
// Shared types and helpers for the multi-channel HLS output-channel wait controller.
package hls_chn_o_pkg;

   typedef enum int {
      MODE_INDEP    = 0,
      MODE_LOCKSTEP = 1
   } lockstep_mode_e;

   // Width needed to count 0..depth entries.
   function automatic int lw_of(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int chn_lsb(input int chn, input int dw);
      return chn * dw;
   endfunction

endpackage

// File: rtl/hls_chn_o_fifo.sv
// Per-channel circular output FIFO; head is zero while empty, no push-to-head bypass.
module hls_chn_o_fifo
   import hls_chn_o_pkg::*;
#(
   parameter int DW    = 17,
   parameter int DEPTH = 2,
   parameter int LW    = lw_of(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_dat,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] lvl,
   output logic [DW-1:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         if (push && !pop)      lvl <= lvl + LW'(1);
         else if (pop && !push) lvl <= lvl - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign full  = (lvl == LW'(DEPTH));
   assign empty = (lvl == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/hls_chn_o_multi_wait_ctrl.sv
// Multi-channel HLS output wait controller: per-channel pending tracking, data hold and FIFO,
// with optional all-or-none acceptance across requesting channels.
module hls_chn_o_multi_wait_ctrl
   import hls_chn_o_pkg::*;
#(
   parameter int NUM_CHN  = 2,
   parameter int DW       = 17,
   parameter int DEPTH    = 2,
   parameter int LOCKSTEP = 0,
   parameter int LW       = lw_of(DEPTH)
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rst,
   input  logic                  core_wen,
   input  logic                  core_wten,
   input  logic [NUM_CHN-1:0]    chn_iswt0,
   input  logic [NUM_CHN-1:0]    chn_ld_core_psct,
   input  logic [NUM_CHN-1:0]    chn_oswt,
   input  logic [NUM_CHN*DW-1:0] chn_core_dat,
   output logic [NUM_CHN-1:0]    chn_o_pvld,
   input  logic [NUM_CHN-1:0]    chn_o_prdy,
   output logic [NUM_CHN*DW-1:0] chn_o_pd,
   output logic [NUM_CHN-1:0]    chn_ld_core_sct,
   output logic [NUM_CHN-1:0]    chn_biwt,
   output logic [NUM_CHN-1:0]    chn_bdwt,
   output logic [NUM_CHN-1:0]    chn_icwt,
   output logic [NUM_CHN*LW-1:0] chn_lvl,
   output logic [NUM_CHN-1:0]    chn_err,
   output logic                  core_stall
);

   logic [NUM_CHN-1:0] pdswt;
   logic [NUM_CHN-1:0] ogwt;
   logic [NUM_CHN-1:0] pop;
   logic [NUM_CHN-1:0] can_acc;
   logic [NUM_CHN-1:0] full;
   logic [NUM_CHN-1:0] empty;
   logic [NUM_CHN-1:0] acc;
   logic [NUM_CHN-1:0] icwt;
   logic               all_ok;
   logic [DW-1:0]      hold [NUM_CHN];

   assign pdswt   = chn_iswt0 & ~{NUM_CHN{core_wten}};
   assign ogwt    = pdswt | icwt;
   assign pop     = chn_o_pvld & chn_o_prdy;
   assign can_acc = ~full | pop;

   // Lockstep: any requester that cannot complete blocks every requester this cycle.
   always_comb begin
      all_ok = &(~ogwt | can_acc);
      if (LOCKSTEP == int'(MODE_LOCKSTEP)) acc = ogwt & {NUM_CHN{all_ok}};
      else                                 acc = ogwt & can_acc;
   end

   assign chn_biwt        = acc;
   assign chn_ld_core_sct = chn_ld_core_psct & acc;
   assign chn_bdwt        = chn_oswt & {NUM_CHN{core_wen}};
   assign chn_icwt        = icwt;
   assign chn_o_pvld      = ~empty;
   assign core_stall      = |(ogwt & ~acc);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         icwt    <= '0;
         chn_err <= '0;
         for (int unsigned i = 0; i < NUM_CHN; i++) hold[i] <= '0;
      end else begin
         icwt    <= ogwt & ~acc;
         chn_err <= chn_err | (pdswt & icwt);
         for (int unsigned i = 0; i < NUM_CHN; i++) begin
            if (pdswt[i] && !icwt[i] && !acc[i])
               hold[i] <= chn_core_dat[chn_lsb(int'(i), DW) +: DW];
         end
      end
   end

   for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
      logic [DW-1:0] push_dat;

      assign push_dat = icwt[g] ? hold[g] : chn_core_dat[chn_lsb(g, DW) +: DW];

      hls_chn_o_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH),
         .LW    (LW)
      ) u_fifo (
         .clk      (nvdla_core_clk),
         .rst      (nvdla_core_rst),
         .push     (acc[g]),
         .pop      (pop[g]),
         .push_dat (push_dat),
         .full     (full[g]),
         .empty    (empty[g]),
         .lvl      (chn_lvl[g*LW +: LW]),
         .head     (chn_o_pd[g*DW +: DW])
      );
   end

endmodule

// File: tb/tb_hls_chn_o_multi_wait_ctrl.sv
// Bench: an independent and a lockstep instance share stimulus; a queue-based model predicts both.
module tb_hls_chn_o_multi_wait_ctrl;

   localparam int NUM_CHN = 2;
   localparam int DW      = 17;
   localparam int DEPTH   = 2;
   localparam int LW      = $clog2(DEPTH + 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  core_wen;
   logic                  core_wten;
   logic [NUM_CHN-1:0]    iswt0;
   logic [NUM_CHN-1:0]    psct;
   logic [NUM_CHN-1:0]    oswt;
   logic [NUM_CHN-1:0]    prdy;
   logic [NUM_CHN*DW-1:0] dat;

   logic [NUM_CHN-1:0]    pvld [2];
   logic [NUM_CHN-1:0]    sct  [2];
   logic [NUM_CHN-1:0]    biwt [2];
   logic [NUM_CHN-1:0]    bdwt [2];
   logic [NUM_CHN-1:0]    icwt [2];
   logic [NUM_CHN-1:0]    err  [2];
   logic [NUM_CHN*DW-1:0] pd   [2];
   logic [NUM_CHN*LW-1:0] lvl  [2];
   logic                  stall[2];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      hls_chn_o_multi_wait_ctrl #(
         .NUM_CHN  (NUM_CHN),
         .DW       (DW),
         .DEPTH    (DEPTH),
         .LOCKSTEP (k)
      ) dut (
         .nvdla_core_clk   (clk),
         .nvdla_core_rst   (rst),
         .core_wen         (core_wen),
         .core_wten        (core_wten),
         .chn_iswt0        (iswt0),
         .chn_ld_core_psct (psct),
         .chn_oswt         (oswt),
         .chn_core_dat     (dat),
         .chn_o_pvld       (pvld[k]),
         .chn_o_prdy       (prdy),
         .chn_o_pd         (pd[k]),
         .chn_ld_core_sct  (sct[k]),
         .chn_biwt         (biwt[k]),
         .chn_bdwt         (bdwt[k]),
         .chn_icwt         (icwt[k]),
         .chn_lvl          (lvl[k]),
         .chn_err          (err[k]),
         .core_stall       (stall[k])
      );
   end

   // Reference model state, index 0 = independent, 1 = lockstep.
   logic [DW-1:0]      mq     [2][NUM_CHN][$];
   logic [DW-1:0]      m_hold [2][NUM_CHN];
   logic [NUM_CHN-1:0] m_icwt [2];
   logic [NUM_CHN-1:0] m_err  [2];
   logic [NUM_CHN-1:0] m_ogwt [2];
   logic [NUM_CHN-1:0] m_pop  [2];
   logic [NUM_CHN-1:0] m_acc  [2];
   logic [NUM_CHN-1:0] m_pdswt;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] dat_of(input int c);
      return dat[c*DW +: DW];
   endfunction

   task automatic set_dat(input int c, input logic [DW-1:0] v);
      dat[c*DW +: DW] = v;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_icwt[k] = '0;
         m_err[k]  = '0;
         for (int c = 0; c < NUM_CHN; c++) begin
            mq[k][c].delete();
            m_hold[k][c] = '0;
         end
      end
   endtask

   task automatic model_eval();
      logic               all_ok;
      logic [NUM_CHN-1:0] can;
      m_pdswt = iswt0 & ~{NUM_CHN{core_wten}};
      for (int k = 0; k < 2; k++) begin
         all_ok = 1'b1;
         for (int c = 0; c < NUM_CHN; c++) begin
            m_ogwt[k][c] = m_pdswt[c] | m_icwt[k][c];
            m_pop[k][c]  = (mq[k][c].size() > 0) && prdy[c];
            can[c]       = (mq[k][c].size() < DEPTH) || m_pop[k][c];
            if (m_ogwt[k][c] && !can[c]) all_ok = 1'b0;
         end
         for (int c = 0; c < NUM_CHN; c++)
            m_acc[k][c] = m_ogwt[k][c] && ((k == 1) ? all_ok : can[c]);
      end
   endtask

   task automatic check_all();
      logic [DW-1:0] exp_pd;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("stall%0d", k), 64'(stall[k]), 64'(|(m_ogwt[k] & ~m_acc[k])));
         check($sformatf("biwt%0d", k), 64'(biwt[k]), 64'(m_acc[k]));
         check($sformatf("sct%0d", k), 64'(sct[k]), 64'(psct & m_acc[k]));
         check($sformatf("bdwt%0d", k), 64'(bdwt[k]), 64'(oswt & {NUM_CHN{core_wen}}));
         check($sformatf("icwt%0d", k), 64'(icwt[k]), 64'(m_icwt[k]));
         check($sformatf("err%0d", k), 64'(err[k]), 64'(m_err[k]));
         for (int c = 0; c < NUM_CHN; c++) begin
            exp_pd = (mq[k][c].size() > 0) ? mq[k][c][0] : '0;
            check($sformatf("pvld%0d_%0d", k, c), 64'(pvld[k][c]), 64'(mq[k][c].size() > 0));
            check($sformatf("lvl%0d_%0d", k, c), 64'(lvl[k][c*LW +: LW]), 64'(mq[k][c].size()));
            check($sformatf("pd%0d_%0d", k, c), 64'(pd[k][c*DW +: DW]), 64'(exp_pd));
         end
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NUM_CHN; c++) begin
            if (m_pop[k][c]) void'(mq[k][c].pop_front());
            if (m_acc[k][c]) mq[k][c].push_back(m_icwt[k][c] ? m_hold[k][c] : dat_of(c));
            if (m_pdswt[c] && !m_icwt[k][c] && !m_acc[k][c]) m_hold[k][c] = dat_of(c);
            if (m_pdswt[c] && m_icwt[k][c]) m_err[k][c] = 1'b1;
         end
         m_icwt[k] = m_ogwt[k] & ~m_acc[k];
      end
   endtask

   // Caller drives inputs at posedge+1; outputs are checked at the falling edge.
   task automatic cycle();
      @(negedge clk);
      model_eval();
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("arst_lvl%0d", k), 64'(lvl[k]), 64'(0));
         check($sformatf("arst_pvld%0d", k), 64'(pvld[k]), 64'(0));
         check($sformatf("arst_err%0d", k), 64'(err[k]), 64'(0));
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle();
      core_wen  = 1'b1;
      core_wten = 1'b0;
      iswt0     = '0;
      psct      = '1;
      oswt      = '1;
      prdy      = '0;
      dat       = '0;
   endtask

   task automatic drain(input int n);
      iswt0 = '0;
      prdy  = '1;
      repeat (n) cycle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state with no requests
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("rst_pvld%0d", k), 64'(pvld[k]), 64'(0));

      // Fill ch0 with downstream stalled, then same-cycle pop+push
      iswt0 = 2'b01;
      set_dat(0, 17'h1ABCD);
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("fill1_lvl%0d", k), 64'(lvl[k][LW-1:0]), 64'(1));
      set_dat(0, 17'h00001);
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("fill2_lvl%0d", k), 64'(lvl[k][LW-1:0]), 64'(2));
      set_dat(0, 17'h00002);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("full_stall%0d", k), 64'(stall[k]), 64'(1));
         check($sformatf("full_biwt%0d", k), 64'(biwt[k]), 64'(0));
      end
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("full_icwt%0d", k), 64'(icwt[k]), 64'(1));
      iswt0 = '0;
      prdy  = 2'b01;
      #1;
      for (int k = 0; k < 2; k++) check($sformatf("pp_biwt%0d", k), 64'(biwt[k]), 64'(1));
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("pp_lvl%0d", k), 64'(lvl[k][LW-1:0]), 64'(2));
      drain(4);

      // Pending write replays the captured data, not the later core data
      prdy  = '0;
      iswt0 = 2'b01;
      set_dat(0, 17'h00011); cycle();
      set_dat(0, 17'h00022); cycle();
      set_dat(0, 17'h00055); cycle();
      iswt0 = '0;
      prdy  = 2'b01;
      set_dat(0, 17'h1FFFF); cycle();
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("replay_pd%0d", k), 64'(pd[k][DW-1:0]), 64'(17'h00055));
      drain(4);

      // Wait-tick enable masks requests; bdwt over all oswt/core_wen combinations
      iswt0     = '1;
      core_wten = 1'b1;
      for (int m = 0; m < 4; m++) begin
         oswt     = {NUM_CHN{m[0]}};
         core_wen = m[1];
         #1;
         for (int k = 0; k < 2; k++) check($sformatf("wten_stall%0d", k), 64'(stall[k]), 64'(0));
         cycle();
         for (int k = 0; k < 2; k++) check($sformatf("wten_icwt%0d", k), 64'(icwt[k]), 64'(0));
      end
      idle();

      // Lockstep: a full ch0 blocks ch1 as well
      iswt0 = 2'b01;
      set_dat(0, 17'h00AAA); cycle();
      set_dat(0, 17'h00BBB); cycle();
      iswt0 = 2'b11;
      set_dat(0, 17'h00CCC);
      set_dat(1, 17'h10101);
      cycle();
      check("ls_icwt", 64'(icwt[1]), 64'(2'b11));
      check("ind_icwt", 64'(icwt[0]), 64'(2'b01));
      iswt0 = '0;
      prdy  = 2'b01;
      #1;
      check("ls_biwt", 64'(biwt[1]), 64'(2'b11));
      cycle();
      drain(5);

      // Protocol error: second request while pending
      prdy  = '0;
      iswt0 = 2'b01;
      set_dat(0, 17'h0A0A0); cycle();
      set_dat(0, 17'h0B0B0); cycle();
      set_dat(0, 17'h0C0C0); cycle();
      set_dat(0, 17'h0D0D0); cycle();
      for (int k = 0; k < 2; k++) check($sformatf("err_set%0d", k), 64'(err[k][0]), 64'(1));
      iswt0 = '0;
      prdy  = 2'b01;
      cycle();
      cycle();
      for (int k = 0; k < 2; k++) check($sformatf("err_hold_pd%0d", k), 64'(pd[k][DW-1:0]), 64'(17'h0C0C0));
      iswt0 = 2'b01;
      set_dat(0, 17'h00123);
      cycle();
      prdy = '0;
      cycle();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("err_sticky%0d", k), 64'(err[k][0]), 64'(1));
         check($sformatf("burst_lvl%0d", k), 64'(lvl[k][LW-1:0]), 64'(2));
      end
      async_reset();
      idle();

      // Randomized traffic with periodic resets
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NUM_CHN; c++)
            iswt0[c] = ($urandom_range(0, 3) != 0) &&
                       (!(m_icwt[0][c] || m_icwt[1][c]) || ($urandom_range(0, 9) == 0));
         psct      = NUM_CHN'($urandom);
         oswt      = NUM_CHN'($urandom);
         prdy      = NUM_CHN'($urandom);
         core_wen  = 1'($urandom);
         core_wten = ($urandom_range(0, 7) == 0);
         dat       = (NUM_CHN*DW)'({$urandom, $urandom});
         cycle();
         if (n % 100 == 99) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
